// File: rtl/seg7_scan.sv
// Purpose : time-multiplexed driver for a 7-digit BCD readout ("d.dddddd") on an 8-digit display.
// Latency : outputs are registered; AN/SEG/DP follow scan state with one clock of delay.
// Backpr. : none; free-running scan, inputs are sampled once per frame and never stalled.
//
// Ports:
//   CLK100MHZ   system clock, rising edge
//   CPU_RESETN  asynchronous active-low reset
//   dig0..dig6  BCD digits (dig0 least significant, dig6 = integer volts digit)
//   AN[7:0]     digit anodes, active-low, AN[0] rightmost
//   SEG[6:0]    cathodes {CG,CF,CE,CD,CC,CB,CA}, active-low
//   DP          decimal-point cathode, active-low
//
// Optional feature: define SEG7_BLANK_GAP_EN to blank the first BLANK_CYCLES
// cycles of every slot (anti-ghosting). Without it BLANK_CYCLES is ignored.
module seg7_scan #(
  parameter int REFRESH_DIV  = 100000,  // cycles per digit slot, >= 2
  parameter int BLANK_CYCLES = 2000     // dark cycles at slot start, 0..REFRESH_DIV-1
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic [3:0] dig0,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  input  logic [3:0] dig4,
  input  logic [3:0] dig5,
  input  logic [3:0] dig6,
  output logic [7:0] AN,
  output logic [6:0] SEG,
  output logic       DP
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

`ifdef SEG7_BLANK_GAP_EN
  localparam int GAP_LEN = BLANK_CYCLES;
`else
  // Gap disabled: the slot anode stays on for the whole slot.
  localparam int GAP_LEN = 0 * BLANK_CYCLES;
`endif

  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [6:0][3:0] snap;

  logic            slot_end;
  logic            blank;
  logic [3:0]      cur;
  logic [7:0]      an_d;
  logic [6:0]      seg_d;
  logic            dp_d;

  // Active-low glyphs; anything outside 0..9 shows a dash.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = 7'h3F;
    endcase
  endfunction

  always_comb begin
    slot_end = (cnt == CNT_MAX);

    cur = 4'h0;
    case (idx)
      3'd0:    cur = snap[0];
      3'd1:    cur = snap[1];
      3'd2:    cur = snap[2];
      3'd3:    cur = snap[3];
      3'd4:    cur = snap[4];
      3'd5:    cur = snap[5];
      3'd6:    cur = snap[6];
      default: cur = 4'h0;
    endcase

    // Slot 7 is always dark so each digit gets exactly 1/8 duty.
    blank = (idx == 3'd7) || (int'(cnt) < GAP_LEN);

    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (!blank) begin
      an_d  = ~(8'h01 << idx);
      seg_d = glyph(cur);
      dp_d  = (idx != 3'd6);
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cnt  <= '0;
      idx  <= '0;
      snap <= '0;
      AN   <= 8'hFF;
      SEG  <= 7'h7F;
      DP   <= 1'b1;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) begin
        idx <= idx + 3'd1;
        // Snapshot only at frame start so a frame never mixes two readings.
        if (idx == 3'd7) begin
          snap <= {dig6, dig5, dig4, dig3, dig2, dig1, dig0};
        end
      end
      AN  <= an_d;
      SEG <= seg_d;
      DP  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
module tb_seg7_scan;

  localparam int RD = 4;
  localparam int BC = 1;
`ifdef SEG7_BLANK_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] dig [7];
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks   = 0;
  int failures = 0;

  exp_t exp_q[$];

  // Reference model state (mirrors the scan position after each edge).
  int         m_cnt;
  int         m_idx;
  logic [3:0] m_snap [7];

  seg7_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .dig0      (dig[0]),
    .dig1      (dig[1]),
    .dig2      (dig[2]),
    .dig3      (dig[3]),
    .dig4      (dig[4]),
    .dig5      (dig[5]),
    .dig6      (dig[6]),
    .AN        (an),
    .SEG       (seg),
    .DP        (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic exp_t model_out(input int i, input int c, input logic [3:0] v);
    exp_t e;
    e.an  = 8'hFF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    if (i != 7 && !(GAP_EN && c < BC)) begin
      e.an[i] = 1'b0;
      e.seg   = ref_glyph(v);
      e.dp    = (i == 6) ? 1'b0 : 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_idx <= 0;
      for (int i = 0; i < 7; i++) m_snap[i] <= 4'h0;
      exp_q.delete();
    end else begin
      exp_q.push_back(model_out(m_idx, m_cnt, m_snap[(m_idx < 7) ? m_idx : 0]));
      if (m_cnt == RD - 1) begin
        m_cnt <= 0;
        m_idx <= (m_idx + 1) % 8;
        if (m_idx == 7)
          for (int i = 0; i < 7; i++) m_snap[i] <= dig[i];
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic test_reset();
    int   n_ff;
    exp_t e;
    for (int i = 0; i < 7; i++) dig[i] = 4'h0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      failures++;
      $display("FAIL reset_async: got AN=%h SEG=%h DP=%b, want FF 7F 1", an, seg, dp);
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      failures++;
      $display("FAIL reset_held: got AN=%h SEG=%h DP=%b, want FF 7F 1", an, seg, dp);
    end
    rst_n = 1'b1;
    n_ff = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (an !== (GAP_EN ? 8'hFF : 8'hFE) || seg !== (GAP_EN ? 7'h7F : 7'h40)) begin
          failures++;
          $display("FAIL first_edge: got AN=%h SEG=%h, want %h %h", an, seg,
                   GAP_EN ? 8'hFF : 8'hFE, GAP_EN ? 7'h7F : 7'h40);
        end
      end
      if (an == 8'hFF) n_ff++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL reset_scan: cycle %0d got no expectation, want one", k);
      end else begin
        e = exp_q.pop_front();
        if ({an, seg, dp} !== e) begin
          failures++;
          $display("FAIL reset_scan: cycle %0d got %h/%h/%b, want %h/%h/%b", k, an, seg, dp, e.an, e.seg, e.dp);
        end
      end
    end
    checks++;
    if (n_ff != (GAP_EN ? 11 : 4)) begin
      failures++;
      $display("FAIL reset_frame_dark: got %0d dark cycles, want %0d", n_ff, GAP_EN ? 11 : 4);
    end
  endtask

  task automatic test_dp_one();
    exp_t e;
    bit   saw = 1'b0;
    for (int i = 0; i < 7; i++) dig[i] = 4'h0;
    dig[6] = 4'h1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (an == 8'hBF && seg == 7'h79 && dp == 1'b0) saw = 1'b1;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL dp_one: cycle %0d got no expectation, want one", k);
      end else begin
        e = exp_q.pop_front();
        if ({an, seg, dp} !== e) begin
          failures++;
          $display("FAIL dp_one: cycle %0d got %h/%h/%b, want %h/%h/%b", k, an, seg, dp, e.an, e.seg, e.dp);
        end
      end
    end
    checks++;
    if (saw !== 1'b1) begin
      failures++;
      $display("FAIL dp_one_glyph: got seen=%b, want 1 (AN=BF SEG=79 DP=0)", saw);
    end
  endtask

  task automatic test_midframe();
    exp_t e;
    bit   saw30 = 1'b0;
    bit   saw78 = 1'b0;
    int   w;
    for (int i = 0; i < 7; i++) dig[i] = 4'h0;
    dig[0] = 4'h3;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (an == 8'hFE && seg == 7'h30) saw30 = 1'b1;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL midframe_pre: cycle %0d got no expectation, want one", k);
      end else begin
        e = exp_q.pop_front();
        if ({an, seg, dp} !== e) begin
          failures++;
          $display("FAIL midframe_pre: cycle %0d got %h/%h/%b, want %h/%h/%b", k, an, seg, dp, e.an, e.seg, e.dp);
        end
      end
    end
    checks++;
    if (saw30 !== 1'b1) begin
      failures++;
      $display("FAIL midframe_30: got seen=%b, want 1", saw30);
    end
    for (w = 0; w < 100 && !(m_idx == 2 && m_cnt == 1); w++) @(negedge clk);
    checks++;
    if (w >= 100) begin
      failures++;
      $display("FAIL midframe_align: got timeout after %0d cycles, want idx=2", w);
    end
    exp_q.delete();
    dig[0] = 4'h7;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      // Slot 0 must not show 7 before the frame boundary (~23 cycles away).
      if (an == 8'hFE && seg == 7'h78) begin
        saw78 = 1'b1;
        checks++;
        if (k < 22) begin
          failures++;
          $display("FAIL midframe_early: got SEG=78 at cycle %0d, want not before 22", k);
        end
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL midframe_post: cycle %0d got no expectation, want one", k);
      end else begin
        e = exp_q.pop_front();
        if ({an, seg, dp} !== e) begin
          failures++;
          $display("FAIL midframe_post: cycle %0d got %h/%h/%b, want %h/%h/%b", k, an, seg, dp, e.an, e.seg, e.dp);
        end
      end
    end
    checks++;
    if (saw78 !== 1'b1) begin
      failures++;
      $display("FAIL midframe_78: got seen=%b, want 1", saw78);
    end
  endtask

  task automatic test_dash();
    exp_t e;
    bit   saw = 1'b0;
    for (int i = 0; i < 7; i++) dig[i] = 4'h0;
    dig[3] = 4'hB;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (an == 8'hF7 && seg == 7'h3F) saw = 1'b1;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL dash: cycle %0d got no expectation, want one", k);
      end else begin
        e = exp_q.pop_front();
        if ({an, seg, dp} !== e) begin
          failures++;
          $display("FAIL dash: cycle %0d got %h/%h/%b, want %h/%h/%b", k, an, seg, dp, e.an, e.seg, e.dp);
        end
      end
    end
    checks++;
    if (saw !== 1'b1) begin
      failures++;
      $display("FAIL dash_glyph: got seen=%b, want 1 (AN=F7 SEG=3F)", saw);
    end
  endtask

  task automatic test_midreset();
    exp_t e;
    int   w;
    for (int i = 0; i < 7; i++) dig[i] = 4'h0;
    dig[0] = 4'h5;
    for (w = 0; w < 100 && !(m_idx == 5 && m_cnt == 2); w++) @(negedge clk);
    checks++;
    if (w >= 100) begin
      failures++;
      $display("FAIL midreset_align: got timeout after %0d cycles, want idx=5 cnt=2", w);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      failures++;
      $display("FAIL midreset_dark: got AN=%h SEG=%h DP=%b, want FF 7F 1", an, seg, dp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      // Snapshot was cleared, so dig0=5 must not reach slot 0 in this frame.
      if (k == 1) begin
        checks++;
        if (an !== 8'hFE || seg !== 7'h40) begin
          failures++;
          $display("FAIL midreset_restart: got AN=%h SEG=%h, want FE 40", an, seg);
        end
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL midreset_scan: cycle %0d got no expectation, want one", k);
      end else begin
        e = exp_q.pop_front();
        if ({an, seg, dp} !== e) begin
          failures++;
          $display("FAIL midreset_scan: cycle %0d got %h/%h/%b, want %h/%h/%b", k, an, seg, dp, e.an, e.seg, e.dp);
        end
      end
    end
  endtask

  task automatic test_gap();
    exp_t e;
    int   w;
    int   n_ff  = 0;
    int   n_fe  = 0;
    int   n_bad = 0;
    int   zeros;
    for (int i = 0; i < 7; i++) dig[i] = 4'(i + 2);
    for (w = 0; w < 100 && !(m_idx == 0 && m_cnt == 0); w++) @(negedge clk);
    checks++;
    if (w >= 100) begin
      failures++;
      $display("FAIL gap_align: got timeout after %0d cycles, want idx=0 cnt=0", w);
    end
    exp_q.delete();
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      zeros = 0;
      for (int b = 0; b < 8; b++) if (an[b] == 1'b0) zeros++;
      if (zeros > 1) n_bad++;
      if (an == 8'hFF) n_ff++;
      if (an == 8'hFE) n_fe++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL gap_scan: cycle %0d got no expectation, want one", k);
      end else begin
        e = exp_q.pop_front();
        if ({an, seg, dp} !== e) begin
          failures++;
          $display("FAIL gap_scan: cycle %0d got %h/%h/%b, want %h/%h/%b", k, an, seg, dp, e.an, e.seg, e.dp);
        end
      end
    end
    checks++;
    if (n_ff != (GAP_EN ? 11 : 4)) begin
      failures++;
      $display("FAIL gap_dark: got %0d dark cycles, want %0d", n_ff, GAP_EN ? 11 : 4);
    end
    checks++;
    if (n_fe != (GAP_EN ? 3 : 4)) begin
      failures++;
      $display("FAIL gap_slot0: got %0d anode-on cycles, want %0d", n_fe, GAP_EN ? 3 : 4);
    end
    checks++;
    if (n_bad != 0) begin
      failures++;
      $display("FAIL onehot: got %0d multi-anode cycles, want 0", n_bad);
    end
  endtask

  initial begin
    test_reset();
    test_dp_one();
    test_midframe();
    test_dash();
    test_midreset();
    test_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (minimum 2; 1 kHz slot rate at 100 MHz).
REQ-002 SHALL have parameter BLANK_CYCLES, default 2000, dark cycles at the start of each slot when SEG7_BLANK_GAP_EN is defined; legal range 0..REFRESH_DIV-1.
REQ-003 SHALL have port CLK100MHZ  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port CPU_RESETN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports dig0..dig6  input  4 each  BCD digits from the voltage converter; dig0 is least significant, dig6 is the integer volts digit.
REQ-006 SHALL have port AN  output  8  digit anodes, active-low, AN[0] rightmost.
REQ-007 SHALL have port SEG  output  7  cathodes, active-low, SEG[6:0] = {CG,CF,CE,CD,CC,CB,CA}.
REQ-008 SHALL have port DP  output  1  decimal-point cathode, active-low.

Function
REQ-009 SHALL keep slot counter cnt: 0..REFRESH_DIV-1, +1 per cycle, wraps to 0.
REQ-010 SHALL keep 3-bit scan index idx, +1 mod 8 on each cycle where cnt==REFRESH_DIV-1.
REQ-011 SHALL load snapshot registers snap0..snap6 from dig0..dig6 on the cycle where cnt==REFRESH_DIV-1 and idx==7, i.e. at frame start; inputs SHALL have no effect on the display at any other time.
REQ-012 SHALL register AN, SEG and DP: the outputs in cycle n+1 are a function of idx, cnt and snap in cycle n. Latency is one clock.
REQ-013 SHALL, for idx k in 0..6, drive AN with only bit k low and SEG=glyph(snapk).
REQ-014 SHALL, for idx 7, drive AN=8'hFF, SEG=7'h7F and DP=1. This dark slot keeps per-digit duty at 1/8.
REQ-015 SHALL drive DP=0 only while idx==6 (displays "d.dddddd"), otherwise DP=1.
REQ-016 SHALL use glyphs (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Values 10..15 SHALL display a dash, 3F.
REQ-017 SHALL pass a snapshot of value 1 at dig6 with zeros elsewhere through unchanged, displaying "1.000000".
REQ-018 SHALL NOT drive more than one AN bit low in any cycle.

Reset
REQ-019 SHALL, while CPU_RESETN=0, immediately and asynchronously force cnt=0, idx=0, snap0..snap6=0, AN=8'hFF, SEG=7'h7F, DP=1.
REQ-020 SHALL, on the first rising edge after reset release, drive AN=8'hFE and SEG=7'h40 (no gap) or keep all dark (gap enabled). The first frame shows "0.000000" until the first snapshot load.
REQ-021 SHALL, when reset is asserted mid-slot or mid-frame, abandon the scan; the next frame restarts at idx 0 with cleared snapshots.

Configuration
REQ-022 SHALL, when macro SEG7_BLANK_GAP_EN is defined, force AN=8'hFF, SEG=7'h7F and DP=1 (registered) while cnt<BLANK_CYCLES, then show the slot digit for the rest of the slot. This is anti-ghosting.
REQ-023 SHALL, when SEG7_BLANK_GAP_EN is undefined, ignore BLANK_CYCLES and assert the slot anode for the full REFRESH_DIV cycles.

Verification (REFRESH_DIV=4, BLANK_CYCLES=1)
REQ-024 SHALL cover: reset release with dig*=0 -> AN=FE then FD, FB ... BF every 4 cycles, SEG=40 throughout, DP=0 only with AN=BF, AN=FF in slot 7.
REQ-025 SHALL cover: dig6..dig0=1,0,0,0,0,0,0 held across a frame boundary -> next frame slot 6 gives SEG=79, DP=0; slots 0-5 give SEG=40.
REQ-026 SHALL cover: dig0 changed from 3 to 7 at mid-frame, idx=2 -> slot 0 keeps SEG=30 until the next frame start, then SEG=78.
REQ-027 SHALL cover: dig3=4'hB -> slot 3 SEG=3F (dash).
REQ-028 SHALL cover: reset asserted at idx=5, cnt=2 -> outputs dark within the same cycle; after release the scan restarts at AN=FE with SEG=40.
REQ-029 SHALL cover: with SEG7_BLANK_GAP_EN defined, each slot -> 1 cycle AN=FF, then 3 cycles of the slot anode low. Without the macro -> 4 cycles of the anode low, and no AN=FF except in slot 7.
